// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int SERIAL_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } serial_state_t;

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the column borrows.
module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_half_subtractor.sv
// Bit-serial LSB-first subtractor: streams A and B in, presents A - B and the
// final borrow as a parallel word over a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for start; no input accepted, no result offered
// ST_RUN  | accepting bit pairs, borrow chained through br
// ST_DONE | diff/borrow offered until out_ready
module serial_half_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    serial_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             br;
    logic             d;
    logic             bout;

    serial_sub_cell u_cell (
        .a    (a_bit),
        .b    (b_bit),
        .bin  (br),
        .d    (d),
        .bout (bout)
    );

    // Bits arrive LSB first, so after WIDTH right shifts bit 0 sits at sr[0].
    assign sr_next = {d, sr[WIDTH-1:1]};

    assign in_ready  = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            sr     <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        sr    <= '0;
                        br    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        sr  <= sr_next;
                        cnt <= cnt + CNT_W'(1);
                        br  <= bout;
                        if (cnt == CNT_LAST) begin
                            state  <= ST_DONE;
                            diff   <= sr_next;
                            borrow <= bout;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_half_subtractor.sv
// Randomised self-checking bench for serial_half_subtractor against an
// arithmetic reference (A - B mod 2^W, borrow = A < B).
module tb_serial_half_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         a_bit = 1'b0;
    logic         b_bit = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         borrow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_half_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'((a + (1 << W) - b) % (1 << W));
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
        return (int'(a) < int'(b));
    endfunction

    // Pulses start, then streams nbits pairs with ngaps idle stretches.
    // glitches counts cycles during the stream where the block left RUN early.
    task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int ngaps, input int nbits, output int glitches);
        int gaps_left;
        logic [31:0] r;
        gaps_left = ngaps;
        glitches  = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (gaps_left > 0 && ((nbits - i) <= gaps_left || $urandom_range(0, 2) == 0)) begin
                int len;
                len = $urandom_range(1, 4);
                gaps_left--;
                for (int g = 0; g < len; g++) begin
                    if (in_ready !== 1'b1 || out_valid !== 1'b0) glitches++;
                    r = $urandom;
                    in_valid = 1'b0;
                    a_bit = r[0];
                    b_bit = r[1];
                    @(negedge clk);
                end
            end
            if (in_ready !== 1'b1 || out_valid !== 1'b0) glitches++;
            in_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        total += 4;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (diff !== '0) begin bad++; $display("FAIL reset_diff got=%h want=00", diff); end
        if (borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b want=0", borrow); end
    endtask

    task automatic test_frame(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input int ngaps);
        int gl;
        feed(a, b, ngaps, W, gl);
        total += 6;
        if (gl !== 0) begin bad++; $display("FAIL %s_run_phase early_exit_cycles=%0d want=0", name, gl); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_out_valid got=%b want=1", name, out_valid); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL %s_in_ready got=%b want=0", name, in_ready); end
        if (diff !== ref_diff(a, b)) begin bad++; $display("FAIL %s_diff got=%h want=%h", name, diff, ref_diff(a, b)); end
        if (borrow !== ref_borrow(a, b)) begin bad++; $display("FAIL %s_borrow got=%b want=%b", name, borrow, ref_borrow(a, b)); end
        handshake();
        if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_release got=%b want=0", name, out_valid); end
    endtask

    task automatic test_basic();
        test_frame("basic", 8'h5A, 8'h3C, 0);
    endtask

    task automatic test_borrow_clear();
        test_frame("underflow", 8'h00, 8'h01, 0);
        test_frame("equal", 8'h80, 8'h80, 0);
    endtask

    task automatic test_gaps();
        test_frame("gaps", 8'hC3, 8'h42, 3);
    endtask

    task automatic test_reset_mid();
        int gl;
        logic [31:0] r;
        feed(8'hFF, 8'h00, 0, 4, gl);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total += 5;
        if (gl !== 0) begin bad++; $display("FAIL midrst_run_phase early_exit_cycles=%0d want=0", gl); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b want=0", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        if (diff !== '0) begin bad++; $display("FAIL midrst_diff got=%h want=00", diff); end
        if (borrow !== 1'b0) begin bad++; $display("FAIL midrst_borrow got=%b want=0", borrow); end
        for (int k = 0; k < 6; k++) begin
            r = $urandom;
            in_valid = 1'b1;
            a_bit = r[0];
            b_bit = r[1];
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL midrst_idle cycle=%0d out_valid=%b in_ready=%b want=0/0", k, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        test_frame("after_rst", 8'h10, 8'h01, 0);
    endtask

    task automatic test_hold();
        logic [W-1:0] a, b;
        int gl;
        a = W'($urandom);
        b = W'($urandom);
        feed(a, b, 1, W, gl);
        total++;
        if (gl !== 0) begin bad++; $display("FAIL hold_run_phase early_exit_cycles=%0d want=0", gl); end
        for (int k = 0; k < 5; k++) begin
            start = (k == 1);
            @(negedge clk);
            total += 3;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_out_valid cycle=%0d got=%b want=1", k, out_valid); end
            if (diff !== ref_diff(a, b)) begin bad++; $display("FAIL hold_diff cycle=%0d got=%h want=%h", k, diff, ref_diff(a, b)); end
            if (borrow !== ref_borrow(a, b)) begin bad++; $display("FAIL hold_borrow cycle=%0d got=%b want=%b", k, borrow, ref_borrow(a, b)); end
        end
        start = 1'b0;
        handshake();
        total += 2;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_release out_valid=%b in_ready=%b want=0/0", out_valid, in_ready);
        end
        @(negedge clk);
        if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_start_ignored in_ready=%b want=0", in_ready); end
    endtask

    task automatic test_idle_valid();
        logic [31:0] r;
        for (int k = 0; k < 6; k++) begin
            r = $urandom;
            in_valid = r[2];
            a_bit = r[0];
            b_bit = r[1];
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_valid cycle=%0d in_ready=%b out_valid=%b want=0/0", k, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        test_frame("post_idle", W'($urandom), W'($urandom), 0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        int gl;
        int wait_n;
        for (int f = 0; f < 12; f++) begin
            a = W'($urandom);
            b = W'($urandom);
            feed(a, b, $urandom_range(0, 3), W, gl);
            wait_n = $urandom_range(0, 3);
            for (int k = 0; k < wait_n; k++) @(negedge clk);
            total += 4;
            if (gl !== 0) begin bad++; $display("FAIL rand%0d_run_phase early_exit_cycles=%0d want=0", f, gl); end
            if (out_valid !== 1'b1) begin bad++; $display("FAIL rand%0d_out_valid got=%b want=1", f, out_valid); end
            if (diff !== ref_diff(a, b)) begin bad++; $display("FAIL rand%0d_diff a=%h b=%h got=%h want=%h", f, a, b, diff, ref_diff(a, b)); end
            if (borrow !== ref_borrow(a, b)) begin bad++; $display("FAIL rand%0d_borrow a=%h b=%h got=%b want=%b", f, a, b, borrow, ref_borrow(a, b)); end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_clear();
        test_gaps();
        test_reset_mid();
        test_hold();
        test_idle_valid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_half_subtractor.md
# serial_half_subtractor

Bit-serial, LSB-first subtractor that computes A − B for two WIDTH-bit operands streamed one bit pair per accepted cycle. A registered borrow carries between bits. The difference is assembled into a parallel word and presented, with the final borrow, through a valid/ready output handshake. It sits beside the combinational half-adder as the inverse arithmetic path, turning serial operand streams into a checked parallel result.

## Interface

Parameters:
- WIDTH, default 8: operand and result width in bits. Must be ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  in  1  a_bit/b_bit are valid this cycle.
- a_bit  in  1  minuend bit, LSB first.
- b_bit  in  1  subtrahend bit, LSB first.
- in_ready  out  1  block accepts a bit pair this cycle; high only in RUN.
- out_valid  out  1  diff/borrow are valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  difference word, (A − B) mod 2^WIDTH.
- borrow  out  1  final borrow, 1 iff A < B unsigned.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - start = 1 → RUN. The same edge clears the borrow register, the bit counter and the shift register.
- RUN:
  - in_ready = 1.
  - A transfer is in_valid && in_ready.
  - On each transfer:
    - d = a ^ b ^ br
    - br_next = (~a & b) | (~(a ^ b) & br)
    - Shift d into the shift register MSB (right shift), increment the counter.
  - The transfer that brings the counter to WIDTH moves the state to DONE. diff takes the final shift-register contents and borrow takes br_next on that same edge.
  - in_valid low: no state change. Gaps of any length are legal.
- DONE:
  - out_valid = 1. diff and borrow hold stable while out_ready = 0.
  - out_valid && out_ready → IDLE. diff and borrow keep their values after leaving DONE and are only meaningful while out_valid = 1.
- start is ignored in RUN and DONE. It does not restart or corrupt the frame.
- in_valid outside RUN is ignored. No bit is consumed.
- Arithmetic is modulo 2^WIDTH. There is no overflow flag; borrow is the only status.

## Timing

- Reset values: state IDLE; in_ready 0, out_valid 0, diff 0, borrow 0; counter 0; borrow register 0.
- Reset wins over every other input in the same cycle, including reset mid-frame and reset in DONE. The partial frame is discarded and no out_valid is produced.
- The start pulse at edge N puts in_ready high from cycle N+1.
- The WIDTH-th transfer at edge M puts out_valid high from cycle M+1, one cycle of latency. in_ready drops in the same cycle.
- The handshake at edge K puts out_valid low from cycle K+1. A new start is accepted from cycle K+1.
- Minimum frame: 1 start cycle + WIDTH bit cycles + 1 result cycle, so WIDTH+2 cycles.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Structure

- Shared package serial_arith_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default width constant SERIAL_WIDTH = 8, shared with any future serial adder.
- Sub-module serial_sub_cell: a combinational 1-bit full subtractor (a, b, bin → d, bout).
  - The top instantiates it once and registers bout as br.
  - The cell is reused by a future serial adder/subtractor block.
- The top holds the FSM, the counter ($clog2(WIDTH+1) bits), the shift register and the output registers.

## Test plan

- 0x5A − 0x3C, LSB-first, in_valid held high → diff = 0x1E, borrow = 0, out_valid 1 cycle after the 8th bit.
- 0x00 − 0x01 → diff = 0xFF, borrow = 1. Then 0x80 − 0x80 → diff = 0x00, borrow = 0. Checks borrow clearing between frames.
- 0xC3 − 0x42 with in_valid low on random cycles, 3 gaps of 1–4 cycles → diff = 0x81, borrow = 0; bit count unaffected by gaps.
- out_ready held low 5 cycles in DONE → diff and borrow stable, out_valid stays 1. A start pulse during the hold is ignored. After the handshake, IDLE.
- rst asserted after 4 bits of a frame → next cycle all outputs 0 and in_ready 0. A following full frame 0x10 − 0x01 → diff = 0x0F, borrow = 0.
- in_valid pulses in IDLE with no start → in_ready stays 0, no out_valid, and the next frame's result is unaffected.
